// File: rtl/sar_code_capture_fifo_if.sv
// Handshake bundle between the SAR capture block and its controller/readout.
// The master side drives conversion control, comparator data and the consumer ready.
interface sar_code_capture_fifo_if #(
  parameter int NBIT  = 12,
  parameter int SEQ_W = 4
);
  logic                  conv_en;
  logic                  bit_stb;
  logic                  comp;
  logic [NBIT-1:0]       trial;
  logic                  busy;
  logic [SEQ_W+NBIT-1:0] dout;
  logic                  dvalid;
  logic                  dready;
  logic                  ovf;
  logic                  ovf_clr;
  logic [7:0]            abort_cnt;

  modport master (
    output conv_en, bit_stb, comp, dready, ovf_clr,
    input  trial, busy, dout, dvalid, ovf, abort_cnt
  );

  modport slave (
    input  conv_en, bit_stb, comp, dready, ovf_clr,
    output trial, busy, dout, dvalid, ovf, abort_cnt
  );
endinterface

// File: rtl/sar_code_capture_fifo.sv
// SAR bit capture, CDAC trial-word drive and tagged code FIFO (FWFT, valid/ready out).
// Code reaches DVALID 2 clocks after the last bit strobe; a full FIFO drops codes and sets sticky OVF.
module sar_code_capture_fifo #(
  parameter int NBIT       = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int SEQ_W      = 4
) (
  input logic                   clk,
  input logic                   rst,
  sar_code_capture_fifo_if.slave bus
);
  localparam int IW = $clog2(NBIT);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(NBIT - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CONV, PUSH} state_t;

  state_t                state, state_nxt;
  logic                  conv_en_d;
  logic [IW-1:0]         idx;
  logic [NBIT-1:0]       code;
  logic [SEQ_W-1:0]      seq;
  logic [SEQ_W+NBIT-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  ovf;
  logic [7:0]            abort_cnt;
  logic [NBIT-1:0]       trial;

  logic start, last, abort, pop, dvalid, push_ok, push_drop;

  assign dvalid    = (count != '0);
  assign pop       = dvalid && bus.dready;
  assign start     = (state == IDLE) && bus.conv_en && !conv_en_d;
  assign last      = (state == CONV) && bus.bit_stb && (idx == '0);
  // Completion beats abort when the final strobe lands on the CONV_EN fall.
  assign abort     = (state == CONV) && !bus.conv_en && !last;
  assign push_ok   = (state == PUSH) && ((count < DEPTH_C) || pop);
  assign push_drop = (state == PUSH) && !push_ok;

  always_comb begin
    state_nxt = state;
    trial     = '0;
    case (state)
      IDLE: if (start) state_nxt = CONV;
      CONV: begin
        // Bits below idx are still zero, so OR-ing in the test bit forms the trial word.
        trial = code | (NBIT'(1) << idx);
        if (last)       state_nxt = PUSH;
        else if (abort) state_nxt = IDLE;
      end
      PUSH: begin
        trial     = code;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      conv_en_d <= 1'b0;
      idx       <= '0;
      code      <= '0;
      seq       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      abort_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      state     <= state_nxt;
      conv_en_d <= bus.conv_en;
      case (state)
        IDLE: if (start) begin
          idx  <= IDX_MAX;
          code <= '0;
        end
        CONV: begin
          if (bus.bit_stb) begin
            code[idx] <= bus.comp;
            if (idx != '0) idx <= idx - 1'b1;
          end
          if (abort && (abort_cnt != 8'hFF)) abort_cnt <= abort_cnt + 1'b1;
        end
        // Tag advances even on a drop so the consumer sees the gap.
        PUSH: seq <= seq + 1'b1;
        default: ;
      endcase
      if (push_ok) begin
        mem[wr_ptr] <= {seq, code};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_drop)        ovf <= 1'b1;
      else if (bus.ovf_clr) ovf <= 1'b0;
    end
  end

  assign bus.trial     = trial;
  assign bus.busy      = (state != IDLE);
  assign bus.dout      = dvalid ? mem[rd_ptr] : '0;
  assign bus.dvalid    = dvalid;
  assign bus.ovf       = ovf;
  assign bus.abort_cnt = abort_cnt;
endmodule

// File: tb/tb_sar_code_capture_fifo.sv
// Directed bench for sar_code_capture_fifo: conversion vector table plus corner-case sequences.
module tb_sar_code_capture_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  sar_code_capture_fifo_if #(.NBIT(12), .SEQ_W(4)) bus ();

  sar_code_capture_fifo #(.NBIT(12), .FIFO_DEPTH(4), .SEQ_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [11:0] bits;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // One full conversion; optional CONV_EN fall on the last strobe, DREADY/OVF_CLR during PUSH.
  task automatic do_conv(input logic [11:0] bits, input bit chk_trial, input bit fall_last,
                         input bit rdy_push, input bit clr_push);
    logic [11:0] built;
    built = '0;
    bus.conv_en = 1'b1;
    tick();
    if (chk_trial) check("busy_conv", {31'b0, bus.busy}, 32'd1);
    for (int i = 11; i >= 0; i--) begin
      if (chk_trial) check("trial_step", {20'b0, bus.trial}, {20'b0, built | (12'h1 << i)});
      bus.bit_stb = 1'b1;
      bus.comp    = bits[i];
      if (i == 0 && fall_last) bus.conv_en = 1'b0;
      tick();
      built[i] = bits[i];
    end
    bus.bit_stb = 1'b0;
    bus.comp    = 1'b0;
    bus.conv_en = 1'b0;
    if (chk_trial) begin
      check("trial_push", {20'b0, bus.trial}, {20'b0, bits});
      check("dvalid_in_push", {31'b0, bus.dvalid}, 32'd0);
    end
    bus.dready  = rdy_push;
    bus.ovf_clr = clr_push;
    tick();
    bus.dready  = 1'b0;
    bus.ovf_clr = 1'b0;
  endtask

  task automatic pop_chk(input string name, input logic [15:0] exp);
    check({name, "_vld"}, {31'b0, bus.dvalid}, 32'd1);
    check(name, {16'b0, bus.dout}, {16'b0, exp});
    bus.dready = 1'b1;
    tick();
    bus.dready = 1'b0;
  endtask

  task automatic do_abort_quick();
    bus.conv_en = 1'b1;
    tick();
    bus.conv_en = 1'b0;
    tick();
  endtask

  initial begin
    vecs[0] = '{bits: 12'h123, exp_dout: 16'h1123};
    vecs[1] = '{bits: 12'hFFF, exp_dout: 16'h2FFF};
    vecs[2] = '{bits: 12'h000, exp_dout: 16'h3000};
    vecs[3] = '{bits: 12'h5A5, exp_dout: 16'h45A5};

    bus.conv_en = 1'b0;
    bus.bit_stb = 1'b0;
    bus.comp    = 1'b0;
    bus.dready  = 1'b0;
    bus.ovf_clr = 1'b0;
    repeat (2) tick();
    check("rst_trial",  {20'b0, bus.trial}, 32'd0);
    check("rst_busy",   {31'b0, bus.busy}, 32'd0);
    check("rst_dvalid", {31'b0, bus.dvalid}, 32'd0);
    check("rst_dout",   {16'b0, bus.dout}, 32'd0);
    check("rst_ovf",    {31'b0, bus.ovf}, 32'd0);
    check("rst_abort",  {24'b0, bus.abort_cnt}, 32'd0);
    rst = 1'b0;
    tick();

    // Abort after 5 strobes
    bus.conv_en = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus.bit_stb = 1'b1;
      bus.comp    = 1'b1;
      tick();
    end
    bus.bit_stb = 1'b0;
    bus.conv_en = 1'b0;
    tick();
    check("abort_cnt1", {24'b0, bus.abort_cnt}, 32'd1);
    check("abort_busy", {31'b0, bus.busy}, 32'd0);
    repeat (2) tick();
    check("abort_dvalid", {31'b0, bus.dvalid}, 32'd0);

    // Normal conversion 0xAAA with TRIAL stepping and 2-cycle latency
    do_conv(12'hAAA, 1'b1, 1'b0, 1'b0, 1'b0);
    pop_chk("conv_aaa", 16'h0AAA);
    check("empty_after_pop", {31'b0, bus.dvalid}, 32'd0);

    for (int v = 0; v < 4; v++) begin
      do_conv(vecs[v].bits, 1'b0, 1'b0, 1'b0, 1'b0);
      pop_chk("table_dout", vecs[v].exp_dout);
    end

    // Overflow: seq 5..8 stored, seq 9 dropped
    for (int i = 0; i < 4; i++) do_conv(12'h123, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_before_drop", {31'b0, bus.ovf}, 32'd0);
    do_conv(12'h123, 1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf_after_drop", {31'b0, bus.ovf}, 32'd1);
    check("dout_hold", {16'b0, bus.dout}, 32'h5123);
    pop_chk("drain0", 16'h5123);
    pop_chk("drain1", 16'h6123);
    pop_chk("drain2", 16'h7123);
    pop_chk("drain3", 16'h8123);
    check("drained_empty", {31'b0, bus.dvalid}, 32'd0);
    do_conv(12'h321, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_chk("seq_gap", 16'hA321);
    bus.ovf_clr = 1'b1;
    tick();
    bus.ovf_clr = 1'b0;
    check("ovf_cleared", {31'b0, bus.ovf}, 32'd0);

    // Full FIFO with pop during PUSH: code accepted, no overflow
    for (int i = 0; i < 4; i++) do_conv(12'h0F0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_head", {16'b0, bus.dout}, 32'hB0F0);
    do_conv(12'h777, 1'b0, 1'b0, 1'b1, 1'b0);
    check("full_pop_ovf", {31'b0, bus.ovf}, 32'd0);
    pop_chk("fp0", 16'hC0F0);
    pop_chk("fp1", 16'hD0F0);
    pop_chk("fp2", 16'hE0F0);
    pop_chk("fp3", 16'hF777);
    check("fp_empty", {31'b0, bus.dvalid}, 32'd0);

    // Last strobe coincident with CONV_EN fall: completes, seq wraps to 0
    do_conv(12'h9C3, 1'b0, 1'b1, 1'b0, 1'b0);
    check("coinc_abort_cnt", {24'b0, bus.abort_cnt}, 32'd1);
    pop_chk("coinc_dout", 16'h09C3);

    // OVF_CLR coincident with a drop: set wins
    for (int i = 0; i < 4; i++) do_conv(12'h111, 1'b0, 1'b0, 1'b0, 1'b0);
    do_conv(12'h111, 1'b0, 1'b0, 1'b0, 1'b1);
    check("ovf_set_wins", {31'b0, bus.ovf}, 32'd1);
    pop_chk("oc0", 16'h1111);
    pop_chk("oc1", 16'h2111);
    pop_chk("oc2", 16'h3111);
    pop_chk("oc3", 16'h4111);

    // Abort counter saturation
    for (int i = 0; i < 253; i++) do_abort_quick();
    check("abort_cnt_254", {24'b0, bus.abort_cnt}, 32'd254);
    for (int i = 0; i < 3; i++) do_abort_quick();
    check("abort_cnt_sat", {24'b0, bus.abort_cnt}, 32'd255);

    // Reset mid-conversion with 2 entries queued
    do_conv(12'h456, 1'b0, 1'b0, 1'b0, 1'b0);
    do_conv(12'h456, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pre_rst_head", {16'b0, bus.dout}, 32'h6456);
    bus.conv_en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      bus.bit_stb = 1'b1;
      bus.comp    = 1'b1;
      tick();
    end
    bus.bit_stb = 1'b0;
    check("pre_rst_busy", {31'b0, bus.busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_dvalid", {31'b0, bus.dvalid}, 32'd0);
    check("rst_mid_busy",   {31'b0, bus.busy}, 32'd0);
    check("rst_mid_trial",  {20'b0, bus.trial}, 32'd0);
    bus.conv_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    do_conv(12'hABC, 1'b0, 1'b0, 1'b0, 1'b0);
    pop_chk("post_rst_seq0", 16'h0ABC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
